// File: rtl/exp3_unidade_controle.sv
// Control FSM for the experiment-3 memory game: sequences 16 plays of
// register / compare / advance and ends in success, error or timeout.
module exp3_unidade_controle #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);

    estado_t     estado;
    estado_t     proximo;
    logic        jogada_s1;
    logic        jogada_s2;
    logic        jogada_ant;
    logic        borda;
    logic [15:0] contagem;

    assign borda = jogada_s2 & ~jogada_ant;

    // A button edge in the same cycle as the timeout wins; edges seen in any
    // other state simply vanish because the detector is a one-cycle pulse.
    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:     if (iniciar) proximo = PREPARA;
            PREPARA:     proximo = ESPERA;
            ESPERA: begin
                if (borda)
                    proximo = REGISTRA;
                else if (contagem == LIMITE)
                    proximo = FIM_TIMEOUT;
            end
            REGISTRA:    proximo = COMPARA;
            COMPARA: begin
                if (!chavesIgualMemoria)
                    proximo = FIM_ERRO;
                else if (fimC)
                    proximo = FIM_ACERTO;
                else
                    proximo = PROXIMO;
            end
            PROXIMO:     proximo = ESPERA;
            FIM_ACERTO:  if (iniciar) proximo = PREPARA;
            FIM_ERRO:    if (iniciar) proximo = PREPARA;
            FIM_TIMEOUT: if (iniciar) proximo = PREPARA;
            default:     proximo = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they are registered
    // alongside the state and stay purely Moore.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado     <= INICIAL;
            jogada_s1  <= 1'b0;
            jogada_s2  <= 1'b0;
            jogada_ant <= 1'b0;
            contagem   <= 16'd0;
            zeraC      <= 1'b0;
            contaC     <= 1'b0;
            zeraR      <= 1'b0;
            registraR  <= 1'b0;
            pronto     <= 1'b0;
            acertou    <= 1'b0;
            errou      <= 1'b0;
            timeout    <= 1'b0;
            db_estado  <= 4'h0;
        end else begin
            jogada_s1  <= jogada;
            jogada_s2  <= jogada_s1;
            jogada_ant <= jogada_s2;
            estado     <= proximo;
            contagem   <= (estado == ESPERA) ? contagem + 16'd1 : 16'd0;
            zeraC      <= (proximo == PREPARA);
            contaC     <= (proximo == PROXIMO);
            zeraR      <= (proximo == PREPARA);
            registraR  <= (proximo == REGISTRA);
            pronto     <= (proximo == FIM_ACERTO) || (proximo == FIM_ERRO) ||
                          (proximo == FIM_TIMEOUT);
            acertou    <= (proximo == FIM_ACERTO);
            errou      <= (proximo == FIM_ERRO);
            timeout    <= (proximo == FIM_TIMEOUT);
            db_estado  <= proximo;
        end
    end

endmodule
